// File: rtl/pd_result_ddr_reader_if.sv
// Bus bundle for pd_result_ddr_reader: DDR word-read channel plus downstream box handshake.
interface pd_result_ddr_reader_if;
   logic [31:0] DDR_READ_ADDR;
   logic        DDR_READ_REQ;
   logic        DDR_READ_READY;
   logic [31:0] DDR_READ_DATA;
   logic        box_valid;
   logic        box_ready;
   logic [11:0] box_x;
   logic [11:0] box_y;
   logic [11:0] box_w;
   logic [11:0] box_h;
   logic [9:0]  box_grade;
   logic [2:0]  box_scale;

   modport master (
      output DDR_READ_ADDR, DDR_READ_REQ,
      input  DDR_READ_READY, DDR_READ_DATA,
      output box_valid, box_x, box_y, box_w, box_h, box_grade, box_scale,
      input  box_ready
   );

   modport slave (
      input  DDR_READ_ADDR, DDR_READ_REQ,
      output DDR_READ_READY, DDR_READ_DATA,
      input  box_valid, box_x, box_y, box_w, box_h, box_grade, box_scale,
      output box_ready
   );
endinterface

// File: rtl/pd_result_ddr_reader.sv
// Walks a detection list in DDR and emits full-resolution boxes one at a time.
// Optional build macro PD_READER_GRADE_FILTER_EN drops boxes below grade_threshold.
module pd_result_ddr_reader #(
   parameter logic [31:0] BASE_ADDR   = 32'h0900_0000,
   parameter int unsigned MAX_ENTRIES = 255,
   parameter int unsigned WINDOW_W    = 70,
   parameter int unsigned WINDOW_H    = 150
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic                   start,
   input  logic [9:0]             grade_threshold,
   pd_result_ddr_reader_if.master bus,
   output logic                   busy,
   output logic                   done,
   output logic [7:0]             box_count,
   output logic [7:0]             err_count
);

   localparam logic [31:0] START_ADDR = BASE_ADDR + 32'd1;
   localparam logic [15:0] MAX_RD     = 16'(MAX_ENTRIES);
   localparam logic [11:0] WIN_W      = 12'(WINDOW_W);
   localparam logic [11:0] WIN_H      = 12'(WINDOW_H);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, EMIT, FIN} state_t;

   state_t      state, state_n;
   logic [31:0] rd_addr;
   logic [15:0] rd_cnt;
   logic [7:0]  box_cnt_r, err_cnt_r;
   logic [11:0] x_r, y_r, w_r, h_r;
   logic [9:0]  g_r;
   logic [2:0]  s_r;

   logic [31:0] word;
   logic [1:0]  tag;
   logic [9:0]  grade, hcnt, vcnt;
   logic [1:0]  sh;
   logic        word_zero, word_err, grade_pass, rd_last_now;

   logic        clr, ld_box, adv_addr, inc_rd, inc_box;
   logic [1:0]  err_add;
   logic [8:0]  err_sum;

   assign word      = bus.DDR_READ_DATA;
   assign tag       = word[31:30];
   assign grade     = word[29:20];
   assign hcnt      = word[19:10];
   assign vcnt      = word[9:0];
   assign word_zero = (word == '0);
   assign word_err  = (tag == 2'b00) && !word_zero;

   // Scales are powers of two, so products reduce to shifts.
   always_comb begin
      sh = 2'd0;
      unique case (tag)
         2'b11:   sh = 2'd2;
         2'b10:   sh = 2'd1;
         default: sh = 2'd0;
      endcase
   end

`ifdef PD_READER_GRADE_FILTER_EN
   assign grade_pass = (grade >= grade_threshold);
`else
   logic unused_threshold;
   assign unused_threshold = ^grade_threshold;
   assign grade_pass       = 1'b1;
`endif

   // Word just returned would be the last one the list is allowed to hold.
   assign rd_last_now = ((rd_cnt + 16'd1) >= MAX_RD);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_n;
   end

   always_comb begin
      state_n  = state;
      clr      = 1'b0;
      ld_box   = 1'b0;
      adv_addr = 1'b0;
      inc_rd   = 1'b0;
      inc_box  = 1'b0;
      err_add  = 2'd0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n = REQ;
               clr     = 1'b1;
            end
         end
         REQ, WAIT: begin
            state_n = WAIT;
            if (bus.DDR_READ_READY) begin
               inc_rd = 1'b1;
               if (word_zero) begin
                  state_n = FIN;
               end else if (!word_err && grade_pass) begin
                  ld_box  = 1'b1;
                  state_n = EMIT;
               end else begin
                  // Skipped word: may also be the one that exhausts the list.
                  err_add = {1'b0, word_err};
                  if (rd_last_now) begin
                     state_n = FIN;
                     err_add = err_add + 2'd1;
                  end else begin
                     state_n  = REQ;
                     adv_addr = 1'b1;
                  end
               end
            end
         end
         EMIT: begin
            if (bus.box_ready) begin
               inc_box = 1'b1;
               if (rd_cnt >= MAX_RD) begin
                  state_n = FIN;
                  err_add = 2'd1;
               end else begin
                  state_n  = REQ;
                  adv_addr = 1'b1;
               end
            end
         end
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign err_sum = {1'b0, err_cnt_r} + {7'd0, err_add};

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         rd_addr   <= START_ADDR;
         rd_cnt    <= '0;
         box_cnt_r <= '0;
         err_cnt_r <= '0;
      end else begin
         if (clr) begin
            rd_addr   <= START_ADDR;
            rd_cnt    <= '0;
            box_cnt_r <= '0;
            err_cnt_r <= '0;
         end else begin
            if (adv_addr) rd_addr <= rd_addr + 32'd1;
            if (inc_rd)   rd_cnt  <= rd_cnt + 16'd1;
            if (inc_box && (box_cnt_r != 8'hFF)) box_cnt_r <= box_cnt_r + 8'd1;
            err_cnt_r <= err_sum[8] ? 8'hFF : err_sum[7:0];
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         x_r <= '0;
         y_r <= '0;
         w_r <= '0;
         h_r <= '0;
         g_r <= '0;
         s_r <= '0;
      end else if (ld_box) begin
         x_r <= {2'b00, hcnt} << sh;
         y_r <= {2'b00, vcnt} << sh;
         w_r <= WIN_W << sh;
         h_r <= WIN_H << sh;
         g_r <= grade;
         s_r <= 3'd1 << sh;
      end
   end

   assign bus.DDR_READ_ADDR = rd_addr;
   assign bus.DDR_READ_REQ  = (state == REQ) || (state == WAIT);
   assign bus.box_valid     = (state == EMIT);
   assign bus.box_x         = x_r;
   assign bus.box_y         = y_r;
   assign bus.box_w         = w_r;
   assign bus.box_h         = h_r;
   assign bus.box_grade     = g_r;
   assign bus.box_scale     = s_r;

   assign busy      = (state == REQ) || (state == WAIT) || (state == EMIT);
   assign done      = (state == FIN);
   assign box_count = box_cnt_r;
   assign err_count = err_cnt_r;

endmodule

// File: tb/tb_pd_result_ddr_reader.sv
// Bench for pd_result_ddr_reader: list-level model, DDR responder and per-cycle box checker.
module tb_pd_result_ddr_reader;
   localparam logic [31:0] BASE = 32'h0900_0000;
   localparam int MAXE = 255;
`ifdef PD_READER_GRADE_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [9:0] thr = '0;
   logic       busy, done;
   logic [7:0] box_count, err_count;

   pd_result_ddr_reader_if bus ();

   pd_result_ddr_reader #(
      .BASE_ADDR(BASE), .MAX_ENTRIES(MAXE), .WINDOW_W(70), .WINDOW_H(150)
   ) dut (
      .sys_clk(clk), .sys_rst(rst), .start(start), .grade_threshold(thr),
      .bus(bus), .busy(busy), .done(done),
      .box_count(box_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [11:0] x, y, w, h;
      logic [9:0]  g;
      logic [2:0]  s;
   } box_t;

   box_t        exp_q[$];
   box_t        last_box, snap, cur;
   logic [31:0] mem [0:299];
   logic [31:0] seen_addr [0:299];
   int          n_checks = 0, n_err = 0;
   int          req_cycles = 1, stall_len = 0, stall_seen = 0;
   int          exp_reads = 0, rd_idx = 0, done_cnt = 0;
   logic [7:0]  exp_bc = '0, exp_ec = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // List-level model: what a full list read must produce.
   task automatic build_model();
      int  boxes, errs;
      bit  term;
      boxes = 0; errs = 0; term = 1'b0;
      exp_q.delete();
      exp_reads = 0;
      for (int i = 0; i < MAXE; i++) begin
         logic [31:0] w;
         int tag, s, g, hc, vc;
         w = mem[i];
         exp_reads++;
         if (w == 32'd0) begin term = 1'b1; break; end
         tag = int'(w[31:30]);
         if (tag == 0) begin errs++; continue; end
         s  = (tag == 3) ? 4 : tag;
         g  = int'(w[29:20]);
         hc = int'(w[19:10]);
         vc = int'(w[9:0]);
         if (FILT && g < int'(thr)) continue;
         exp_q.push_back('{x: 12'(hc * s), y: 12'(vc * s), w: 12'(70 * s),
                           h: 12'(150 * s), g: 10'(g), s: 3'(s)});
         boxes++;
      end
      if (!term) errs++;
      exp_bc = (boxes > 255) ? 8'd255 : 8'(boxes);
      exp_ec = (errs > 255) ? 8'd255 : 8'(errs);
   endtask

   // Responder, box sink and per-cycle checker, all on the falling edge.
   initial begin : drv
      int req_cnt, vcnt;
      bit prev_stall, prev_done;
      req_cnt = 0; vcnt = 0; prev_stall = 1'b0; prev_done = 1'b0;
      bus.DDR_READ_READY = 1'b0;
      bus.DDR_READ_DATA  = '0;
      bus.box_ready      = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus.DDR_READ_READY = 1'b0;
            bus.box_ready = 1'b0;
            req_cnt = 0; vcnt = 0; prev_stall = 1'b0; prev_done = 1'b0; rd_idx = 0;
            continue;
         end
         if (start && !busy) rd_idx = 0;
         if (done) begin
            chk("done_single", 64'(prev_done), 64'd0);
            chk("done_busy", 64'(busy), 64'd0);
            chk("box_count", 64'(box_count), 64'(exp_bc));
            chk("err_count", 64'(err_count), 64'(exp_ec));
            chk("read_count", 64'(rd_idx), 64'(exp_reads));
            chk("boxes_left", 64'(exp_q.size()), 64'd0);
            done_cnt++;
         end
         prev_done = done;
         if (bus.DDR_READ_REQ || bus.box_valid) chk("busy", 64'(busy), 64'd1);
         cur = {bus.box_x, bus.box_y, bus.box_w, bus.box_h, bus.box_grade, bus.box_scale};
         if (bus.box_valid) begin
            chk("req_during_box", 64'(bus.DDR_READ_REQ), 64'd0);
            if (exp_q.size() == 0) chk("unexpected_box", 64'(bus.box_valid), 64'd0);
            else begin
               chk("box_x", 64'(cur.x), 64'(exp_q[0].x));
               chk("box_y", 64'(cur.y), 64'(exp_q[0].y));
               chk("box_w", 64'(cur.w), 64'(exp_q[0].w));
               chk("box_h", 64'(cur.h), 64'(exp_q[0].h));
               chk("box_grade", 64'(cur.g), 64'(exp_q[0].g));
               chk("box_scale", 64'(cur.s), 64'(exp_q[0].s));
            end
            if (prev_stall) chk("box_hold", 64'(cur), 64'(snap));
         end
         if (bus.DDR_READ_READY) begin
            bus.DDR_READ_READY = 1'b0;
            req_cnt = 0;
         end else if (bus.DDR_READ_REQ) begin
            req_cnt++;
            if (req_cnt >= req_cycles) begin
               chk("ddr_addr", 64'(bus.DDR_READ_ADDR), 64'(BASE + 32'd1 + 32'(rd_idx)));
               if (rd_idx < 300) begin
                  seen_addr[rd_idx] = bus.DDR_READ_ADDR;
                  bus.DDR_READ_DATA = mem[rd_idx];
               end else bus.DDR_READ_DATA = '0;
               bus.DDR_READ_READY = 1'b1;
               rd_idx++;
               req_cnt = 0;
            end
         end else req_cnt = 0;
         if (bus.box_valid) begin
            bus.box_ready = (vcnt >= stall_len);
            vcnt++;
            snap = cur;
            prev_stall = !bus.box_ready;
            if (!bus.box_ready) stall_seen++;
            else begin
               last_box = cur;
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               vcnt = 0;
            end
         end else begin
            bus.box_ready = 1'b0;
            vcnt = 0;
            prev_stall = 1'b0;
         end
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 300; i++) begin
         mem[i] = '0;
         seen_addr[i] = '0;
      end
   endtask

   task automatic run_list(input string name, input bit poke);
      int d0;
      d0 = done_cnt;
      build_model();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 0; c < 20000 && done_cnt == d0; c++) begin
         @(posedge clk);
         if (poke && c == 8) begin
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
         end
      end
      chk({name, "_done"}, 64'(done_cnt - d0), 64'd1);
      repeat (2) @(posedge clk);
   endtask

   initial begin : main
      clear_mem();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_addr", 64'(bus.DDR_READ_ADDR), 64'h0900_0001);
      chk("rst_req", 64'(bus.DDR_READ_REQ), 64'd0);
      chk("rst_valid", 64'(bus.box_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_counts", 64'({box_count, err_count}), 64'd0);
      chk("rst_box", 64'({bus.box_x, bus.box_y, bus.box_w, bus.box_h, bus.box_grade, bus.box_scale}), 64'd0);
      @(posedge clk); #2 rst = 1'b0;

      // Single scale-4 box.
      mem[0] = 32'hC000_2C0A;
      run_list("basic", 1'b0);
      chk("basic_x", 64'(last_box.x), 64'd44);
      chk("basic_y", 64'(last_box.y), 64'd40);
      chk("basic_w", 64'(last_box.w), 64'd280);
      chk("basic_h", 64'(last_box.h), 64'd600);
      chk("basic_s", 64'(last_box.s), 64'd4);
      chk("basic_cnt", 64'(box_count), 64'd1);

      // Slow DDR: REQ held five cycles per word.
      clear_mem();
      mem[0] = 32'h8000_0C03;
      req_cycles = 5;
      run_list("delay", 1'b0);
      chk("delay_addr0", 64'(seen_addr[0]), 64'h0900_0001);
      chk("delay_addr1", 64'(seen_addr[1]), 64'h0900_0002);
      chk("delay_x", 64'(last_box.x), 64'd6);
      chk("delay_w", 64'(last_box.w), 64'd140);
      req_cycles = 1;

      // Back-pressure for 10 cycles, with a stray start while busy.
      stall_len = 10;
      stall_seen = 0;
      run_list("stall", 1'b1);
      chk("stall_cycles", 64'(stall_seen), 64'd10);
      chk("stall_cnt", 64'(box_count), 64'd1);
      stall_len = 0;

      // Invalid tag-00 word followed by a valid one.
      clear_mem();
      mem[0] = 32'h0000_0401;
      mem[1] = 32'h4140_0805;
      run_list("err", 1'b0);
      chk("err_err", 64'(err_count), 64'd1);
      chk("err_cnt", 64'(box_count), 64'd1);
      chk("err_box", 64'({last_box.x, last_box.y, last_box.g, last_box.s}),
          64'({12'd2, 12'd5, 10'd20, 3'd1}));

      // Unterminated list of 300 valid words.
      clear_mem();
      for (int i = 0; i < 300; i++) mem[i] = {2'b01, 10'd7, 10'(i), 10'(i + 1)};
      run_list("overflow", 1'b0);
      chk("ovf_cnt", 64'(box_count), 64'd255);
      chk("ovf_err", 64'(err_count), 64'd1);
      chk("ovf_reads", 64'(rd_idx), 64'd255);
      chk("ovf_last_x", 64'(last_box.x), 64'd254);

      // Grade filter, threshold 10, grades 5 and 20.
      clear_mem();
      mem[0] = {2'b10, 10'd5, 10'd1, 10'd1};
      mem[1] = {2'b10, 10'd20, 10'd2, 10'd2};
      thr = 10'd10;
      run_list("filter", 1'b0);
`ifdef PD_READER_GRADE_FILTER_EN
      chk("filter_cnt", 64'(box_count), 64'd1);
`else
      chk("filter_cnt", 64'(box_count), 64'd2);
`endif
      chk("filter_last_g", 64'(last_box.g), 64'd20);
      chk("filter_last_x", 64'(last_box.x), 64'd4);
      thr = '0;

      // Asynchronous reset in the middle of a read, then a clean reread.
      clear_mem();
      mem[0] = 32'hC000_2C0A;
      req_cycles = 40;
      build_model();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_req", 64'(bus.DDR_READ_REQ), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_addr", 64'(bus.DDR_READ_ADDR), 64'h0900_0001);
      @(posedge clk); #2 rst = 1'b0;
      req_cycles = 1;
      run_list("reread", 1'b0);
      chk("reread_addr", 64'(seen_addr[0]), 64'h0900_0001);
      chk("reread_cnt", 64'(box_count), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
